// File: rtl/mycpu_pkg.sv
// mycpu_pkg: definitions shared by the myCPU MEM stage.
//   - loadStoreMode bit positions
//   - data access size codes
//   - MEM stage FSM state encoding
//   - small address helpers used for alignment and fault detection
package mycpu_pkg;

    // loadStoreMode bit positions (bits [1:0] carry the size code)
    localparam int LSM_STORE    = 5;
    localparam int LSM_LOAD     = 4;
    localparam int LSM_RSVD     = 3;
    localparam int LSM_UNSIGNED = 2;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_WAIT_DATA = 1'b1
    } mem_state_e;

    // Low address bits after forcing natural alignment for the access size.
    // The unused code 2'b11 is handled like a word.
    function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    align_lo = lo;
            SZ_H:    align_lo = {lo[1], 1'b0};
            default: align_lo = 2'b00;
        endcase
    endfunction

    // True when the address is not naturally aligned for the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_B:    misaligned = 1'b0;
            SZ_H:    misaligned = lo[0];
            default: misaligned = |lo;
        endcase
    endfunction

endpackage

// File: rtl/mycpu_mem_stage_if.sv
// mycpu_mem_stage_if: SRAM-like data bus between the MEM stage and data memory.
//   req/wr/size/addr/wstrb/wdata : request side, driven by the master
//   addr_ok                      : request accepted by the slave
//   data_ok/rdata                : read data valid or write done
// Modports: master (MEM stage), slave (memory / bench).
interface mycpu_mem_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  wr;
    logic [1:0]            size;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/mycpu_mem_align.sv
// mycpu_mem_align: combinational data steering for the MEM stage.
//   mode_i       : loadStoreMode from EX
//   addr_lo_i    : low two bits of the aligned effective address
//   store_data_i : store source register (rt)
//   rdata_i      : raw read data from the bus
//   wstrb_o      : byte write enables (zero for non-stores)
//   wdata_o      : store data replicated across the byte lanes
//   load_data_o  : extracted and sign/zero-extended load value
module mycpu_mem_align
    import mycpu_pkg::*;
(
    input  logic [5:0]  mode_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        uns;

    assign byte_sel = rdata_i[8*addr_lo_i +: 8];
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    assign uns      = mode_i[LSM_UNSIGNED];

    always_comb begin
        wstrb_o     = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = rdata_i;
        case (mode_i[1:0])
            SZ_B: begin
                wdata_o     = {4{store_data_i[7:0]}};
                wstrb_o     = 4'b0001 << addr_lo_i;
                load_data_o = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                wdata_o     = {2{store_data_i[15:0]}};
                wstrb_o     = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                load_data_o = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
            end
            default: ;
        endcase
        // Loads never write, whatever the size.
        if (!mode_i[LSM_STORE]) wstrb_o = 4'b0000;
    end

endmodule

// File: rtl/mycpu_mem_stage.sv
// mycpu_mem_stage: MEM stage of the 5-stage myCPU pipeline.
//   clk, rst        : clock (rising edge), asynchronous active-high reset
//   EXE2MEM_*       : EX/MEM pipeline register contents
//   mem_stall       : EX must hold its register while high
//   bus (master)    : SRAM-like data bus (req/addr_ok/data_ok)
//   MEM2WB_*        : MEM/WB pipeline register
// Build option: define MEM_ADDR_EXC_EN to add MEM2WB_excAdel; misaligned
// halfword/word accesses then retire as address errors without touching
// the bus. Without it misaligned addresses are silently aligned down.
module mycpu_mem_stage
    import mycpu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               EXE2MEM_instValid,
    input  logic [4:0]         EXE2MEM_targetReg,
    input  logic [31:0]        EXE2MEM_storeCont,
    input  logic [31:0]        EXE2MEM_pc,
    input  logic               EXE2MEM_regfileWen,
    input  logic [5:0]         EXE2MEM_loadStoreMode,
    input  logic [31:0]        EXE2MEM_aluResult,

    output logic               mem_stall,

    mycpu_mem_stage_if.master  bus,

    output logic               MEM2WB_instValid,
    output logic [4:0]         MEM2WB_targetReg,
    output logic               MEM2WB_regfileWen,
    output logic [31:0]        MEM2WB_pc,
`ifdef MEM_ADDR_EXC_EN
    output logic               MEM2WB_excAdel,
`endif
    output logic [31:0]        MEM2WB_result
);

    mem_state_e  state_q, state_d;

    logic        valid_q;
    logic [4:0]  tgt_q;
    logic        wen_q;
    logic [31:0] pc_q;
    logic [31:0] result_q;

    logic [5:0]  mode;
    logic [1:0]  size;
    logic        any_mem;
    logic        misal;
    logic        memop;
    logic        is_load;
    logic        req_c;
    logic        stall_c;
    logic [1:0]  addr_lo;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] load_data;
    logic        unused_rsvd;

    assign mode    = EXE2MEM_loadStoreMode;
    assign size    = mode[1:0];
    assign any_mem = EXE2MEM_instValid & (mode[LSM_STORE] | mode[LSM_LOAD]);
    // Both load and store set is illegal; it behaves as a store.
    assign is_load = mode[LSM_LOAD] & ~mode[LSM_STORE];
    assign addr_lo = align_lo(size, EXE2MEM_aluResult[1:0]);

`ifdef MEM_ADDR_EXC_EN
    assign misal = any_mem & misaligned(size, EXE2MEM_aluResult[1:0]);
`else
    assign misal = 1'b0;
`endif

    // Only accesses that actually go to the bus count as memops.
    assign memop = any_mem & ~misal;

    assign unused_rsvd = mode[LSM_RSVD];

    mycpu_mem_align u_align (
        .mode_i       (mode),
        .addr_lo_i    (addr_lo),
        .store_data_i (EXE2MEM_storeCont),
        .rdata_i      (bus.rdata[31:0]),
        .wstrb_o      (wstrb),
        .wdata_o      (wdata),
        .load_data_o  (load_data)
    );

    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        stall_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (memop) begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    if (bus.addr_ok) state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                // EX advances in the same cycle the response arrives.
                stall_c = memop & ~bus.data_ok;
                if (bus.data_ok) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gate with rst so the bus and EX see a quiet stage while reset is held,
    // even if EX still presents a memory instruction.
    assign bus.req    = req_c & ~rst;
    assign mem_stall  = stall_c & ~rst;
    assign bus.wr     = mode[LSM_STORE];
    assign bus.size   = size;
    assign bus.addr   = {EXE2MEM_aluResult[ADDR_W-1:2], addr_lo};
    assign bus.wstrb  = wstrb;
    assign bus.wdata  = wdata;

`ifdef MEM_ADDR_EXC_EN
    logic exc_q;
    assign MEM2WB_excAdel = exc_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            valid_q  <= 1'b0;
            tgt_q    <= '0;
            wen_q    <= 1'b0;
            pc_q     <= '0;
            result_q <= '0;
`ifdef MEM_ADDR_EXC_EN
            exc_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (stall_c) begin
                // Bubble into WB while the access is outstanding.
                valid_q <= 1'b0;
                wen_q   <= 1'b0;
`ifdef MEM_ADDR_EXC_EN
                exc_q   <= 1'b0;
`endif
            end else begin
                valid_q  <= EXE2MEM_instValid;
                tgt_q    <= EXE2MEM_targetReg;
                wen_q    <= EXE2MEM_regfileWen & ~misal;
                pc_q     <= EXE2MEM_pc;
                result_q <= (memop & is_load) ? load_data : EXE2MEM_aluResult;
`ifdef MEM_ADDR_EXC_EN
                exc_q    <= misal;
`endif
            end
        end
    end

    assign MEM2WB_instValid  = valid_q;
    assign MEM2WB_targetReg  = tgt_q;
    assign MEM2WB_regfileWen = wen_q;
    assign MEM2WB_pc         = pc_q;
    assign MEM2WB_result     = result_q;

endmodule

// File: tb/tb_mycpu_mem_stage.sv
// tb_mycpu_mem_stage: directed self-checking bench for mycpu_mem_stage.
// Inputs change 1 time unit after the rising edge; combinational outputs
// are checked 1 unit later, registered outputs 1 unit after the next edge.
module tb_mycpu_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_tgt;
    logic [31:0] ex_store;
    logic [31:0] ex_pc;
    logic        ex_wen;
    logic [5:0]  ex_mode;
    logic [31:0] ex_alu;
    logic        mem_stall;
    logic        wb_valid;
    logic [4:0]  wb_tgt;
    logic        wb_wen;
    logic [31:0] wb_pc;
    logic [31:0] wb_result;
`ifdef MEM_ADDR_EXC_EN
    logic        wb_exc;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mycpu_mem_stage_if bus();

    mycpu_mem_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .EXE2MEM_instValid     (ex_valid),
        .EXE2MEM_targetReg     (ex_tgt),
        .EXE2MEM_storeCont     (ex_store),
        .EXE2MEM_pc            (ex_pc),
        .EXE2MEM_regfileWen    (ex_wen),
        .EXE2MEM_loadStoreMode (ex_mode),
        .EXE2MEM_aluResult     (ex_alu),
        .mem_stall             (mem_stall),
        .bus                   (bus.master),
        .MEM2WB_instValid      (wb_valid),
        .MEM2WB_targetReg      (wb_tgt),
        .MEM2WB_regfileWen     (wb_wen),
        .MEM2WB_pc             (wb_pc),
`ifdef MEM_ADDR_EXC_EN
        .MEM2WB_excAdel        (wb_exc),
`endif
        .MEM2WB_result         (wb_result)
    );

    task automatic set_ex(input logic v, input logic [5:0] m, input logic [31:0] alu,
                          input logic [31:0] st, input logic [31:0] pc,
                          input logic wen, input logic [4:0] tgt);
        ex_valid = v; ex_mode = m; ex_alu = alu; ex_store = st;
        ex_pc = pc; ex_wen = wen; ex_tgt = tgt;
    endtask

    task automatic tick;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", wb_valid); end
        checks++; if (wb_tgt !== 5'd0) begin errors++; $display("FAIL reset_tgt got %0d exp 0", wb_tgt); end
        checks++; if (wb_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %0b exp 0", wb_wen); end
        checks++; if (wb_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", wb_pc); end
        checks++; if (wb_result !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp 0", wb_result); end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", bus.req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", mem_stall); end
    endtask

    task automatic test_nonmem;
        set_ex(1'b1, 6'b000000, 32'h1234_5678, 32'h0, 32'h100, 1'b1, 5'd5);
        #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL nonmem_req got %0b exp 0", bus.req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL nonmem_stall got %0b exp 0", mem_stall); end
        tick;
        checks++; if (wb_result !== 32'h1234_5678) begin errors++; $display("FAIL nonmem_result got %h exp 12345678", wb_result); end
        checks++; if (wb_wen !== 1'b1) begin errors++; $display("FAIL nonmem_wen got %0b exp 1", wb_wen); end
        checks++; if (wb_tgt !== 5'd5) begin errors++; $display("FAIL nonmem_tgt got %0d exp 5", wb_tgt); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL nonmem_valid got %0b exp 1", wb_valid); end
        checks++; if (wb_pc !== 32'h100) begin errors++; $display("FAIL nonmem_pc got %h exp 100", wb_pc); end
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL nonmem_req2 got %0b exp 0", bus.req); end
        set_ex(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
    endtask

    // LB, LBU, LH, LHU against rdata 0x80FF_FF00.
    task automatic test_load_extract;
        logic [5:0]  modes [4];
        logic [31:0] addrs [4];
        logic [31:0] exps  [4];
        modes = '{6'b010000, 6'b010100, 6'b010001, 6'b010101};
        addrs = '{32'h1003, 32'h1003, 32'h1000, 32'h1002};
        exps  = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_FF00, 32'h0000_80FF};
        for (int i = 0; i < 4; i++) begin
            set_ex(1'b1, modes[i], addrs[i], 32'h0, 32'h200 + 32'(i*4), 1'b1, 5'd7);
            bus.addr_ok = 1'b1;
            #1;
            checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL ld%0d_req got %0b exp 1", i, bus.req); end
            checks++; if (bus.addr !== addrs[i]) begin errors++; $display("FAIL ld%0d_addr got %h exp %h", i, bus.addr, addrs[i]); end
            checks++; if (bus.wr !== 1'b0) begin errors++; $display("FAIL ld%0d_wr got %0b exp 0", i, bus.wr); end
            checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL ld%0d_stall got %0b exp 1", i, mem_stall); end
            tick;
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL ld%0d_bubble got %0b exp 0", i, wb_valid); end
            bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h80FF_FF00;
            #1;
            checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL ld%0d_req_wait got %0b exp 0", i, bus.req); end
            checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL ld%0d_stall_ok got %0b exp 0", i, mem_stall); end
            tick;
            bus.data_ok = 1'b0;
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ld%0d_valid got %0b exp 1", i, wb_valid); end
            checks++; if (wb_result !== exps[i]) begin errors++; $display("FAIL ld%0d_result got %h exp %h", i, wb_result, exps[i]); end
            checks++; if (wb_tgt !== 5'd7) begin errors++; $display("FAIL ld%0d_tgt got %0d exp 7", i, wb_tgt); end
        end
        set_ex(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
    endtask

    task automatic test_store;
        // SH upper half
        set_ex(1'b1, 6'b100001, 32'h2002, 32'hAAAA_BEEF, 32'h300, 1'b0, 5'd0);
        bus.addr_ok = 1'b1;
        #1;
        checks++; if (bus.wdata !== 32'hBEEF_BEEF) begin errors++; $display("FAIL sh_wdata got %h exp beefbeef", bus.wdata); end
        checks++; if (bus.wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb got %b exp 1100", bus.wstrb); end
        checks++; if (bus.wr !== 1'b1) begin errors++; $display("FAIL sh_wr got %0b exp 1", bus.wr); end
        checks++; if (bus.addr !== 32'h2002) begin errors++; $display("FAIL sh_addr got %h exp 2002", bus.addr); end
        checks++; if (bus.size !== 2'b01) begin errors++; $display("FAIL sh_size got %b exp 01", bus.size); end
        tick;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b1;
        tick;
        bus.data_ok = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL sh_valid got %0b exp 1", wb_valid); end
        checks++; if (wb_result !== 32'h2002) begin errors++; $display("FAIL sh_result got %h exp 2002", wb_result); end
        checks++; if (wb_wen !== 1'b0) begin errors++; $display("FAIL sh_wen got %0b exp 0", wb_wen); end
        // SB at byte 1; check the request only, then complete it
        set_ex(1'b1, 6'b100000, 32'h2001, 32'h1234_56EF, 32'h304, 1'b0, 5'd0);
        bus.addr_ok = 1'b1;
        #1;
        checks++; if (bus.wdata !== 32'hEFEF_EFEF) begin errors++; $display("FAIL sb_wdata got %h exp efefefef", bus.wdata); end
        checks++; if (bus.wstrb !== 4'b0010) begin errors++; $display("FAIL sb_wstrb got %b exp 0010", bus.wstrb); end
        tick;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b1;
        tick;
        bus.data_ok = 1'b0;
        set_ex(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
    endtask

    // LW: addr_ok on the 3rd request cycle, data_ok two cycles after that.
    task automatic test_lw_delay;
        int reqcnt = 0;
        set_ex(1'b1, 6'b010010, 32'h3000, 32'h0, 32'h400, 1'b1, 5'd9);
        bus.rdata = 32'h1357_2468;
        for (int c = 0; c < 5; c++) begin
            bus.addr_ok = (c == 2);
            bus.data_ok = (c == 4);
            #1;
            if (bus.req === 1'b1) reqcnt++;
            checks++; if (bus.req !== (c < 3)) begin errors++; $display("FAIL lwd_req_c%0d got %0b exp %0b", c, bus.req, (c < 3)); end
            checks++; if (mem_stall !== (c < 4)) begin errors++; $display("FAIL lwd_stall_c%0d got %0b exp %0b", c, mem_stall, (c < 4)); end
            tick;
            checks++; if (wb_valid !== (c == 4)) begin errors++; $display("FAIL lwd_valid_c%0d got %0b exp %0b", c, wb_valid, (c == 4)); end
        end
        bus.addr_ok = 1'b0; bus.data_ok = 1'b0;
        checks++; if (reqcnt != 3) begin errors++; $display("FAIL lwd_reqcnt got %0d exp 3", reqcnt); end
        checks++; if (wb_result !== 32'h1357_2468) begin errors++; $display("FAIL lwd_result got %h exp 13572468", wb_result); end
        set_ex(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
    endtask

    task automatic test_back_to_back;
        set_ex(1'b1, 6'b100010, 32'h4000, 32'h1122_3344, 32'h500, 1'b0, 5'd0);
        bus.addr_ok = 1'b1;
        #1;
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL b2b_sw_req got %0b exp 1", bus.req); end
        checks++; if (bus.wstrb !== 4'b1111) begin errors++; $display("FAIL b2b_sw_wstrb got %b exp 1111", bus.wstrb); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL b2b_sw_stall got %0b exp 1", mem_stall); end
        tick;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b1;
        #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL b2b_gap_req got %0b exp 0", bus.req); end
        tick;
        bus.data_ok = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_sw_valid got %0b exp 1", wb_valid); end
        checks++; if (wb_pc !== 32'h500) begin errors++; $display("FAIL b2b_sw_pc got %h exp 500", wb_pc); end
        checks++; if (wb_result !== 32'h4000) begin errors++; $display("FAIL b2b_sw_result got %h exp 4000", wb_result); end
        set_ex(1'b1, 6'b010010, 32'h4004, 32'h0, 32'h504, 1'b1, 5'd10);
        bus.addr_ok = 1'b1;
        #1;
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL b2b_lw_req got %0b exp 1", bus.req); end
        checks++; if (bus.addr !== 32'h4004) begin errors++; $display("FAIL b2b_lw_addr got %h exp 4004", bus.addr); end
        checks++; if (bus.wr !== 1'b0) begin errors++; $display("FAIL b2b_lw_wr got %0b exp 0", bus.wr); end
        tick;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_lw_bubble got %0b exp 0", wb_valid); end
        bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'hCAFE_F00D;
        tick;
        bus.data_ok = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_lw_valid got %0b exp 1", wb_valid); end
        checks++; if (wb_pc !== 32'h504) begin errors++; $display("FAIL b2b_lw_pc got %h exp 504", wb_pc); end
        checks++; if (wb_result !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_lw_result got %h exp cafef00d", wb_result); end
        set_ex(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
    endtask

    task automatic test_reset_mid;
        set_ex(1'b1, 6'b000000, 32'hDEAD, 32'h0, 32'h700, 1'b1, 5'd4);
        tick;
        set_ex(1'b1, 6'b010010, 32'h5000, 32'h0, 32'h704, 1'b1, 5'd3);
        bus.addr_ok = 1'b1;
        tick;
        bus.addr_ok = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %0b exp 0", bus.req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got %0b exp 0", mem_stall); end
        checks++; if (wb_pc !== 32'h0) begin errors++; $display("FAIL rstmid_pc got %h exp 0", wb_pc); end
        checks++; if (wb_result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h exp 0", wb_result); end
        checks++; if (wb_tgt !== 5'd0) begin errors++; $display("FAIL rstmid_tgt got %0d exp 0", wb_tgt); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %0b exp 0", wb_valid); end
        tick;
        rst = 1'b0;
        #1;
        // FSM must be back in IDLE: the held LW requests again.
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL rstmid_idle_req got %0b exp 1", bus.req); end
        set_ex(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
    endtask

    task automatic test_misaligned;
        set_ex(1'b1, 6'b010010, 32'h1001, 32'h0, 32'h800, 1'b1, 5'd2);
`ifdef MEM_ADDR_EXC_EN
        #1;
        checks++; if (bus.req !== 1'b0) begin errors++; $display("FAIL mis_req got %0b exp 0", bus.req); end
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL mis_stall got %0b exp 0", mem_stall); end
        tick;
        checks++; if (wb_exc !== 1'b1) begin errors++; $display("FAIL mis_exc got %0b exp 1", wb_exc); end
        checks++; if (wb_result !== 32'h1001) begin errors++; $display("FAIL mis_result got %h exp 1001", wb_result); end
        checks++; if (wb_wen !== 1'b0) begin errors++; $display("FAIL mis_wen got %0b exp 0", wb_wen); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got %0b exp 1", wb_valid); end
`else
        bus.addr_ok = 1'b1;
        #1;
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL mis_req got %0b exp 1", bus.req); end
        checks++; if (bus.addr !== 32'h1000) begin errors++; $display("FAIL mis_addr got %h exp 1000", bus.addr); end
        tick;
        bus.addr_ok = 1'b0; bus.data_ok = 1'b1; bus.rdata = 32'h0BAD_CAFE;
        tick;
        bus.data_ok = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL mis_valid got %0b exp 1", wb_valid); end
        checks++; if (wb_result !== 32'h0BAD_CAFE) begin errors++; $display("FAIL mis_result got %h exp 0badcafe", wb_result); end
`endif
        set_ex(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        tick;
    endtask

    initial begin
        rst = 1'b1;
        set_ex(1'b0, 6'b0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0);
        bus.addr_ok = 1'b0; bus.data_ok = 1'b0; bus.rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        test_reset;
        rst = 1'b0;
        test_nonmem;
        test_load_extract;
        test_store;
        test_lw_delay;
        test_back_to_back;
        test_reset_mid;
        test_misaligned;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
